// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising receive-side checker for the XNOR LFSR pattern generator
// Ports:
//   i_Clk        clock, rising edge
//   i_Rst        synchronous active-high reset
//   i_Valid      i_Data carries a new sequence word this cycle
//   i_Data       received LFSR word, MSB is bit NUM_BITS-1
//   o_Locked     checker is locked to the sequence
//   o_Error      one-cycle pulse, locked-state word mismatched the prediction
//   o_Match      one-cycle pulse, locked-state word matched the prediction
//   o_Err_Count  saturating count of locked-state mismatches, cleared only by reset
module lfsr_checker #(
    parameter int NUM_BITS   = 4,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Valid,
    input  logic [NUM_BITS-1:0] i_Data,
    output logic                o_Locked,
    output logic                o_Error,
    output logic                o_Match,
    output logic [ERR_W-1:0]    o_Err_Count
);

    // Tap table shared with the generator; bit k-1 set for generator tap k.
    function automatic logic [31:0] f_taps(input int n);
        case (n)
            3:  return 32'h0000_0006;
            4:  return 32'h0000_000C;
            5:  return 32'h0000_0014;
            6:  return 32'h0000_0030;
            7:  return 32'h0000_0060;
            8:  return 32'h0000_00B8;
            9:  return 32'h0000_0110;
            10: return 32'h0000_0240;
            11: return 32'h0000_0500;
            12: return 32'h0000_0829;
            13: return 32'h0000_100D;
            14: return 32'h0000_2015;
            15: return 32'h0000_6000;
            16: return 32'h0000_D008;
            17: return 32'h0001_2000;
            18: return 32'h0002_0400;
            19: return 32'h0004_0023;
            20: return 32'h0009_0000;
            21: return 32'h0014_0000;
            22: return 32'h0030_0000;
            23: return 32'h0042_0000;
            24: return 32'h00E1_0000;
            25: return 32'h0120_0000;
            26: return 32'h0200_0023;
            27: return 32'h0400_0013;
            28: return 32'h0900_0000;
            29: return 32'h1400_0000;
            30: return 32'h2000_0029;
            31: return 32'h4800_0000;
            32: return 32'h8020_0003;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [NUM_BITS-1:0] f_mask();
        logic [31:0]         t;
        logic [NUM_BITS-1:0] m;
        t = f_taps(NUM_BITS);
        m = '0;
        for (int i = 0; i < NUM_BITS; i++)
            m[i] = (i < 32) ? t[i] : 1'b0;
        return m;
    endfunction

    localparam logic [NUM_BITS-1:0] MASK   = f_mask();
    localparam logic [3:0]          LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0]          LOSS_N = 4'(LOSS_COUNT);

    // An empty mask (unsupported width) must give fb=0, not the XNOR of nothing.
    function automatic logic [NUM_BITS-1:0] f_next(input logic [NUM_BITS-1:0] w);
        logic fb;
        fb = (MASK != '0) & ~^(w & MASK);
        return (w << 1) | NUM_BITS'(fb);
    endfunction

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} t_state;

    t_state              r_State;
    logic [NUM_BITS-1:0] r_Pred;
    logic [3:0]          r_Match_Cnt;
    logic [3:0]          r_Miss_Cnt;
    logic                r_Locked;
    logic                r_Error;
    logic                r_Match;
    logic [ERR_W-1:0]    r_Err_Count;

    logic                w_Hit;
    logic                w_Ones;
    logic [NUM_BITS-1:0] w_Next_Data;
    logic [NUM_BITS-1:0] w_Next_Pred;

    assign w_Hit       = (i_Data == r_Pred);
    assign w_Ones      = &i_Data;
    assign w_Next_Data = f_next(i_Data);
    assign w_Next_Pred = f_next(r_Pred);

    // All-ones is the XNOR lockup word: it predicts itself, so it is never
    // accepted as a match while acquiring.  Once locked, the prediction
    // flywheels from itself so a corrupted word cannot poison the next one.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State     <= HUNT;
            r_Pred      <= '0;
            r_Match_Cnt <= '0;
            r_Miss_Cnt  <= '0;
            r_Locked    <= 1'b0;
            r_Error     <= 1'b0;
            r_Match     <= 1'b0;
            r_Err_Count <= '0;
        end else begin
            r_Error <= 1'b0;
            r_Match <= 1'b0;
            if (i_Valid) begin
                case (r_State)
                    HUNT: begin
                        if (!w_Ones) begin
                            r_Pred      <= w_Next_Data;
                            r_Match_Cnt <= '0;
                            r_State     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        r_Pred <= w_Next_Data;
                        if (w_Hit && !w_Ones) begin
                            r_Match_Cnt <= r_Match_Cnt + 4'd1;
                            if (r_Match_Cnt + 4'd1 == LOCK_N) begin
                                r_State    <= LOCKED;
                                r_Locked   <= 1'b1;
                                r_Miss_Cnt <= '0;
                            end
                        end else begin
                            r_Match_Cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        r_Pred <= w_Next_Pred;
                        if (w_Hit) begin
                            r_Match    <= 1'b1;
                            r_Miss_Cnt <= '0;
                        end else begin
                            r_Error    <= 1'b1;
                            r_Miss_Cnt <= r_Miss_Cnt + 4'd1;
                            if (r_Err_Count != '1)
                                r_Err_Count <= r_Err_Count + ERR_W'(1);
                            if (r_Miss_Cnt + 4'd1 == LOSS_N) begin
                                r_State  <= HUNT;
                                r_Locked <= 1'b0;
                            end
                        end
                    end
                    default: r_State <= HUNT;
                endcase
            end
        end
    end

    assign o_Locked    = r_Locked;
    assign o_Error     = r_Error;
    assign o_Match     = r_Match;
    assign o_Err_Count = r_Err_Count;

endmodule
